// File: rtl/pipeline_stream_serializer.sv
// Splits one WIDTH*RATIO word into RATIO WIDTH-bit slices on a registered valid/ready output.
// Latency 1 cycle from accept to slice 0; output held stable under backpressure, next word accepted on the last slice.
module pipeline_stream_serializer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RATIO     = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     input_valid_i,
    output logic                     input_ready_o,
    input  logic [WIDTH*RATIO-1:0]   input_data_i,
    output logic                     output_valid_o,
    input  logic                     output_ready_i,
    output logic [WIDTH-1:0]         output_data_o,
    output logic                     output_last_o
);

    localparam int unsigned   CW       = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

    localparam logic [0:0] ST_EMPTY  = 1'b0;
    localparam logic [0:0] ST_SERIAL = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH*RATIO-1:0] hold_q, hold_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   last_q, last_d;

    logic accept;
    logic xfer;

    function automatic logic [WIDTH-1:0] slice_of(input logic [WIDTH*RATIO-1:0] word,
                                                  input logic [CW-1:0]          k);
        int unsigned idx;
        idx = LSB_FIRST ? 32'(k) : (RATIO - 1 - 32'(k));
        return word[idx*WIDTH +: WIDTH];
    endfunction

    assign output_valid_o = (state_q == ST_SERIAL);
    assign output_data_o  = data_q;
    assign output_last_o  = last_q;

    // Reset and clear both block acceptance so no word is lost across a flush.
    assign input_ready_o = rst_ni & ~clear_i &
                           ((state_q == ST_EMPTY) | (output_valid_o & output_last_o & output_ready_i));

    assign accept = input_valid_i & input_ready_o;
    assign xfer   = output_valid_o & output_ready_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        data_d  = data_q;
        last_d  = last_q;
        if (clear_i) begin
            state_d = ST_EMPTY;
            cnt_d   = '0;
            hold_d  = '0;
            data_d  = '0;
            last_d  = 1'b0;
        end else if (accept) begin
            // Covers both the idle load and the no-bubble handoff on a last-slice transfer.
            state_d = ST_SERIAL;
            cnt_d   = '0;
            hold_d  = input_data_i;
            data_d  = slice_of(input_data_i, '0);
            last_d  = (RATIO == 1);
        end else if (xfer) begin
            if (last_q) begin
                state_d = ST_EMPTY;
                last_d  = 1'b0;
            end else begin
                cnt_d  = cnt_q + CW'(1);
                data_d = slice_of(hold_q, cnt_q + CW'(1));
                last_d = ((cnt_q + CW'(1)) == LAST_IDX);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
            hold_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

endmodule
